// File: rtl/axil_arb_pkg.sv
// Shared constants for the AXI4-Lite write arbiter: FSM state encodings,
// AXI response codes and the fixed protection value.
// Also provides resp_is_err(), which classifies a B-channel response.
package axil_arb_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR are reported to the requester as an error
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic is_err;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   is_err = 1'b0;
      RESP_SLVERR, RESP_DECERR: is_err = 1'b1;
      default:                  is_err = 1'b1;
    endcase
    return is_err;
  endfunction

endpackage

// File: rtl/axil_write_arbiter_rr.sv
// Round-robin first-set search over a request vector, starting at last+1.
// Purely combinational; the "last" pointer is owned by the caller.
// No backpressure of its own: the caller decides when a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               grant_vld_o,
  output logic [IW-1:0]      grant_idx_o
);

  // Walk NUM_REQ positions starting just after last; the first hit wins
  always_comb begin
    logic [31:0] pos;
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    pos         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = (32'(last_i) + 32'(i)) % 32'(NUM_REQ);
      if (!grant_vld_o && req_i[pos]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axil_write_arbiter.sv
// Shares one AXI4-Lite write port between NUM_REQ requesters, round-robin.
// Latency: grant to AW/W 1 cycle, ack 3 cycles after grant with a ready slave.
// Backpressure: AW/W valids hold until handshake; optional watchdog via AXIL_ARB_TIMEOUT_EN.
module axil_write_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          aclk,
  input  logic                          arst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic [ADDR_WIDTH-1:0]         m_axil_awaddr,
  output logic [2:0]                    m_axil_awprot,
  output logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  output logic [DATA_WIDTH-1:0]         m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_axil_wstrb,
  output logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  input  logic [1:0]                    m_axil_bresp,
  input  logic                          m_axil_bvalid,
  output logic                          m_axil_bready
);

  localparam int IW = $clog2(NUM_REQ);

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  err_q, err_d;

  logic                  arb_vld;
  logic [IW-1:0]         arb_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  tmo_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i       (req),
    .last_i      (last_q),
    .grant_vld_o (arb_vld),
    .grant_idx_o (arb_idx)
  );

  // Pick the address/data slice belonging to the arbiter's candidate
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Watchdog: zero while idle, counts every cycle spent in WRITE or RESP
  always_ff @(posedge aclk) begin
    if (arst) begin
      tmo_q <= '0;
    end else if (state_q == ST_WRITE || state_q == ST_RESP) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

  // The comparison is one below the limit so the abort happens after exactly
  // TIMEOUT_CYCLES cycles in WRITE/RESP
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // Next-state logic for the grant/transfer/response/ack sequence
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gidx_d    = gidx_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gidx_d    = arb_idx;
          last_d    = arb_idx;
          awaddr_d  = sel_addr;
          wdata_d   = sel_data;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          err_d     = 1'b0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A cleared valid means that channel already completed
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axil_bvalid) begin
          err_d   = resp_is_err(m_axil_bresp);
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Watchdog abort; a response arriving on the same edge still wins
    if (tmo_hit && (state_q == ST_WRITE || (state_q == ST_RESP && !m_axil_bvalid))) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_DONE;
    end
  end

  // State registers; last starts at NUM_REQ-1 so requester 0 wins first
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      last_q    <= IW'(NUM_REQ - 1);
      gidx_q    <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gidx_q    <= gidx_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      err_q     <= err_d;
    end
  end

  // Ack/err pulse to the granted requester during the single DONE cycle
  always_comb begin
    ack = '0;
    err = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == ST_DONE && gidx_q == IW'(i)) begin
        ack[i] = 1'b1;
        err[i] = err_q;
      end
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign grant_idx      = gidx_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = AXIL_PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = (state_q == ST_RESP);

endmodule

// File: tb/tb_axil_write_arbiter.sv
// Directed bench for axil_write_arbiter: single write, contention, skewed
// handshake, error response, mid-transaction reset and the watchdog path
// (AXIL_ARB_TIMEOUT_EN selects which watchdog expectation applies).
module tb_axil_write_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            aclk = 1'b0;
  logic            arst;
  logic [NR-1:0]   req;
  logic [AW-1:0]   addr0, addr1;
  logic [DW-1:0]   data0, data1;
  logic [NR-1:0]   ack, err;
  logic            busy;
  logic [0:0]      grant_idx;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  axil_write_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .aclk           (aclk),
    .arst           (arst),
    .req            (req),
    .req_addr       ({addr1, addr0}),
    .req_data       ({data1, data0}),
    .ack            (ack),
    .err            (err),
    .busy           (busy),
    .grant_idx      (grant_idx),
    .m_axil_awaddr  (awaddr),
    .m_axil_awprot  (awprot),
    .m_axil_awvalid (awvalid),
    .m_axil_awready (awready),
    .m_axil_wdata   (wdata),
    .m_axil_wstrb   (wstrb),
    .m_axil_wvalid  (wvalid),
    .m_axil_wready  (wready),
    .m_axil_bresp   (bresp),
    .m_axil_bvalid  (bvalid),
    .m_axil_bready  (bready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst = 1'b1; req = '0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    awready = 1'b1; wready = 1'b1; bresp = 2'b00; bvalid = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid",  64'(wvalid),  64'd0);
    check("rst_bready",  64'(bready),  64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_gidx",    64'(grant_idx), 64'd0);
    check("rst_ack",     64'(ack),     64'd0);
    check("rst_awaddr",  64'(awaddr),  64'd0);
    check("awprot",      64'(awprot),  64'd0);
    check("wstrb",       64'(wstrb),   64'hF);
    arst = 1'b0;

    // Single write, always-ready slave (bvalid held high, ignored until RESP)
    req = 2'b01; addr0 = 32'h4; data0 = 32'hDEADBEEF;
    tick();
    check("s_c1_awvalid", 64'(awvalid), 64'd1);
    check("s_c1_wvalid",  64'(wvalid),  64'd1);
    check("s_c1_awaddr",  64'(awaddr),  64'h4);
    check("s_c1_wdata",   64'(wdata),   64'hDEADBEEF);
    check("s_c1_bready",  64'(bready),  64'd0);
    check("s_c1_busy",    64'(busy),    64'd1);
    tick();
    check("s_c2_bready",  64'(bready),  64'd1);
    check("s_c2_awvalid", 64'(awvalid), 64'd0);
    check("s_c2_ack",     64'(ack),     64'd0);
    tick();
    check("s_c3_ack",     64'(ack),     64'b01);
    check("s_c3_err",     64'(err),     64'b00);
    check("s_c3_busy",    64'(busy),    64'd1);
    req = 2'b00;
    tick();
    check("s_c4_ack",     64'(ack),     64'd0);
    check("s_c4_busy",    64'(busy),    64'd0);

    // Contention after reset: grants alternate 0,1,0,1
    arst = 1'b1; tick(); arst = 1'b0;
    addr0 = 32'h10; addr1 = 32'h20; data0 = 32'hA0; data1 = 32'hB1;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gidx",   64'(grant_idx), 64'(k % 2));
      check("rr_awaddr", 64'(awaddr), (k % 2 == 0) ? 64'h10 : 64'h20);
      tick(); tick();
      check("rr_ack",    64'(ack), (k % 2 == 0) ? 64'b01 : 64'b10);
      if (k == 3) req = 2'b00;
      tick();
    end
    check("rr_idle_busy", 64'(busy), 64'd0);

    // Skewed handshake: awready arrives in the 4th WRITE cycle, wready at once
    req = 2'b01; addr0 = 32'h30; data0 = 32'h55AA; awready = 1'b0;
    tick();
    check("sk_c1_aw", 64'(awvalid), 64'd1);
    check("sk_c1_w",  64'(wvalid),  64'd1);
    tick();
    check("sk_c2_w",  64'(wvalid),  64'd0);
    check("sk_c2_aw", 64'(awvalid), 64'd1);
    check("sk_c2_addr", 64'(awaddr), 64'h30);
    tick();
    check("sk_c3_aw", 64'(awvalid), 64'd1);
    check("sk_c3_ack", 64'(ack), 64'd0);
    tick();
    check("sk_c4_aw", 64'(awvalid), 64'd1);
    check("sk_c4_addr", 64'(awaddr), 64'h30);
    awready = 1'b1;
    tick();
    check("sk_c5_aw",  64'(awvalid), 64'd0);
    check("sk_c5_ack", 64'(ack), 64'd0);
    tick();
    check("sk_c6_ack", 64'(ack), 64'b01);
    req = 2'b00;
    tick();
    check("sk_c7_ack", 64'(ack), 64'd0);
    tick();
    check("sk_c8_ack", 64'(ack), 64'd0);

    // Error response to requester 1
    req = 2'b10; addr1 = 32'h44; data1 = 32'h1234; bresp = 2'b10;
    tick();
    check("er_gidx", 64'(grant_idx), 64'd1);
    tick(); tick();
    check("er_ack", 64'(ack), 64'b10);
    check("er_err", 64'(err), 64'b10);
    req = 2'b00; bresp = 2'b00;
    tick();
    check("er_ack_after", 64'(ack), 64'd0);
    check("er_err_after", 64'(err), 64'd0);

    // Reset pulsed while waiting in RESP, then requester 1 served normally
    bvalid = 1'b0; req = 2'b01; addr0 = 32'h50;
    tick(); tick();
    check("mr_bready_pre", 64'(bready), 64'd1);
    arst = 1'b1;
    tick();
    check("mr_bready", 64'(bready), 64'd0);
    check("mr_busy",   64'(busy),   64'd0);
    check("mr_gidx",   64'(grant_idx), 64'd0);
    check("mr_ack",    64'(ack),    64'd0);
    arst = 1'b0; req = 2'b10; addr1 = 32'h60; bvalid = 1'b1;
    tick();
    check("mr2_gidx",   64'(grant_idx), 64'd1);
    check("mr2_awaddr", 64'(awaddr), 64'h60);
    tick(); tick();
    check("mr2_ack", 64'(ack), 64'b10);
    check("mr2_err", 64'(err), 64'b00);
    req = 2'b00;
    tick();

    // Slave never responds
    bvalid = 1'b0; req = 2'b01; addr0 = 32'h70;
`ifdef AXIL_ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) tick();
    check("to_c8_bready", 64'(bready), 64'd1);
    check("to_c8_ack",    64'(ack),    64'd0);
    tick();
    check("to_ack",     64'(ack),     64'b01);
    check("to_err",     64'(err),     64'b01);
    check("to_bready",  64'(bready),  64'd0);
    check("to_awvalid", 64'(awvalid), 64'd0);
    check("to_wvalid",  64'(wvalid),  64'd0);
    req = 2'b00;
    tick();
    check("to_busy_after", 64'(busy), 64'd0);
`else
    for (int c = 0; c < 12; c++) tick();
    check("nt_busy",   64'(busy),   64'd1);
    check("nt_bready", 64'(bready), 64'd1);
    check("nt_ack",    64'(ack),    64'd0);
    req = 2'b00; arst = 1'b1;
    tick();
    arst = 1'b0;
    check("nt_busy_rst", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_write_arbiter.md
Name: axil_write_arbiter

Overview:
- Round-robin scheduler that shares one AXI4-Lite slave write port (the DAC config/register slave) between NUM_REQ local requesters, e.g. JTAG-bridge shadow logic and a sequencer.
- Each requester issues a simple req/addr/data command. The block serialises the commands into single AXI-Lite write transactions.
- It returns a one-cycle ack, with err on a non-OKAY response.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, AXI-Lite address width
- DATA_WIDTH, 32, AXI-Lite data width (32 only)
- TIMEOUT_CYCLES, 255, watchdog limit; used only with AXIL_ARB_TIMEOUT_EN

Ports:
- aclk  in  1  clock, all logic rising edge
- arst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester command valid, held until ack
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, slice i = requester i
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  NUM_REQ  one-cycle error flag, coincident with ack
- busy  out  1  high from grant until the ack cycle inclusive
- grant_idx  out  $clog2(NUM_REQ)  index of the current/last granted requester
- m_axil_awaddr  out  ADDR_WIDTH
- m_axil_awprot  out  3  constant 3'b000
- m_axil_awvalid  out  1
- m_axil_awready  in  1
- m_axil_wdata  out  DATA_WIDTH
- m_axil_wstrb  out  DATA_WIDTH/8  constant all ones
- m_axil_wvalid  out  1
- m_axil_wready  in  1
- m_axil_bresp  in  2
- m_axil_bvalid  in  1
- m_axil_bready  out  1

Behaviour:
- Reset (arst=1 at an edge): state IDLE. awvalid, wvalid, bready, ack, err, busy = 0. grant_idx = 0. awaddr/wdata = 0. RR pointer "last" = NUM_REQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: if any req bit is set, pick the first set bit searching from last+1 modulo NUM_REQ. Register its addr/data, set grant_idx and last, busy=1. Next state WRITE.
  - WRITE: awvalid and wvalid both assert on entry. Each drops independently the cycle after its own handshake (valid&ready at an edge). Address and data may complete in either order or together. When both have completed, next state RESP.
  - RESP: bready=1. On bvalid at an edge, capture err_q = bresp[1] (SLVERR/DECERR). Next state DONE.
  - DONE: ack[grant_idx]=1 and err[grant_idx]=err_q for exactly one cycle, busy still 1. Next state IDLE, busy=0.
- Best-case latency with an always-ready slave:
  - req seen in IDLE at cycle 0.
  - awvalid/wvalid at cycle 1.
  - bready at cycle 2; bvalid same cycle.
  - ack at cycle 3.
  - Back-to-back commands: one transaction per 4 cycles.
- Requester contract: req, addr and data stay stable until ack. req drops on the edge that ends the ack cycle. A req still high in the IDLE cycle after DONE is a new command.
- A req deasserted before grant is simply not served. A req deasserted after grant is ignored; the transaction completes.
- Simultaneous requests: strict round-robin, so no requester is granted twice while another is pending.
- awaddr/wdata hold stable while their valid is high. AXI valids never drop without a handshake, except under reset or timeout.
- Reset mid-transaction: all outputs return to reset values at the next edge. No ack is generated; the abandoned command must be reissued.
- bvalid outside RESP is ignored, because bready=0.

Optional Feature:
- Macro AXIL_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on WRITE entry and increments each cycle in WRITE/RESP.
  - On reaching TIMEOUT_CYCLES, deassert awvalid/wvalid/bready and go to DONE with err=1.
  - This is a debug-recovery path; the AXI protocol violation it causes is accepted.
- When undefined: no counter, TIMEOUT_CYCLES unused, the block waits indefinitely.

Decomposition:
- Package axil_arb_pkg holds:
  - state enum (IDLE, WRITE, RESP, DONE)
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - constant AXIL_PROT_DEFAULT=3'b000
- One sub-module rr_arbiter: combinational first-set search from last+1 over a NUM_REQ-wide vector. Outputs are grant_valid and grant index; "last" stays in the parent.

Test Plan:
- Single write, always-ready slave:
  - Stimulus: req[0] with addr 0x4, data 0xDEADBEEF.
  - Response: awaddr 0x4 and wdata 0xDEADBEEF with both valids at cycle 1, bready at cycle 2, ack[0]=1 and err[0]=0 at cycle 3.
- Contention:
  - Stimulus: req=2'b11 held continuously, each requester reissuing after ack.
  - Response: grants alternate 0,1,0,1. After reset the first grant is 0.
- Skewed handshake:
  - Stimulus: awready delayed 3 cycles, wready immediate.
  - Response: wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable, ack exactly once.
- Error response:
  - Stimulus: slave returns bresp=2'b10 to requester 1.
  - Response: ack[1]=1 and err[1]=1 in the same single cycle, no ack/err on requester 0.
- Reset mid-transaction:
  - Stimulus: arst pulsed during RESP.
  - Response: bready=0, busy=0, grant_idx=0 next cycle, no ack.
  - Then a new req[1] is served normally.
- Timeout (AXIL_ARB_TIMEOUT_EN defined):
  - Stimulus: TIMEOUT_CYCLES=8, slave never asserts bvalid.
  - Response: ack=1 and err=1 after 8 cycles in WRITE/RESP, valids/bready deasserted.
  - Without the macro, busy stays high.
